// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the unified-memory arbiter.
// The memory is 32 x 8; the lower half is the write-protected instruction region.
package mem_arb_pkg;

  localparam int ADDR_W_DEFAULT    = 5;
  localparam int DATA_W_DEFAULT    = 8;
  localparam int DATA_BASE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-requester round-robin picker: bit 0 is the fetch unit, bit 1 the data unit.
// On a tie the requester that did not win last time is chosen.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_i,
  output owner_e     winner_o
);

  always_comb begin
    case (req_i)
      2'b01:   winner_o = FETCH;
      2'b10:   winner_o = DATA;
      2'b11:   winner_o = (last_i == DATA) ? FETCH : DATA;
      default: winner_o = last_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and data accesses onto the single-port unified memory,
// one access per three cycles, blocking data writes into the instruction region.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int DATA_BASE = DATA_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(DATA_BASE);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            lastOwner_q, lastOwner_d;
  owner_e            winner;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
  logic [DATA_W-1:0] dRdata_q, dRdata_d;
  logic              anyReq;
  logic              blockedWrite;

  assign anyReq = if_req | d_req;

  mem_arb_rr2 u_rr2 (
    .req_i   ({d_req, if_req}),
    .last_i  (lastOwner_q),
    .winner_o(winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requests are latched only at the IDLE edge; later input changes are ignored.
  always_comb begin
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    ifRdata_d   = ifRdata_q;
    dRdata_d    = dRdata_q;
    if (state_q == IDLE && anyReq) begin
      owner_d     = winner;
      lastOwner_d = winner;
      addr_d      = (winner == FETCH) ? if_addr : d_addr;
      we_d        = (winner == DATA) & d_we;
      wdata_d     = (winner == DATA) ? d_wdata : '0;
    end
    if (state_q == ACCESS && !we_q) begin
      if (owner_q == FETCH) ifRdata_d = mem_rdata;
      else                  dRdata_d  = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= FETCH;
      lastOwner_q <= DATA;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      ifRdata_q   <= '0;
      dRdata_q    <= '0;
    end else begin
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      ifRdata_q   <= ifRdata_d;
      dRdata_q    <= dRdata_d;
    end
  end

  assign blockedWrite = (owner_q == DATA) && we_q && (addr_q < BaseAddr);

  // Memory strobes decode straight from the state register so reset kills them at once.
  always_comb begin
    mem_w_en  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    d_err     = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_w_en  = (owner_q == DATA) && we_q && (addr_q >= BaseAddr);
      end
      DONE: begin
        if_ack = (owner_q == FETCH);
        d_ack  = (owner_q == DATA);
        d_err  = blockedWrite;
      end
      default: ;
    endcase
  end

  assign if_rdata = ifRdata_q;
  assign d_rdata  = dRdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts the ack
// order and read data; a monitor checks every ack against the predicted queue.
module tb_mem_arbiter;

  localparam int BASE = 16;

  typedef struct {
    bit         isData;
    logic [7:0] rdata;
    bit         err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       ifReq, ifAck, dReq, dWe, dAck, dErr, memWEn, busy;
  logic [4:0] ifAddr, dAddr, memAddr;
  logic [7:0] ifRdata, dWdata, dRdata, memWdata, memRdata;

  logic [7:0] mem    [32];
  logic [7:0] refMem [32];
  exp_t       expQ[$];
  bit         lastWasData;
  logic [7:0] lastDRead;
  int         vectors = 0;
  int         miscompares = 0;

  mem_arbiter dut (
    .clk      (clk),
    .rst      (rstN),
    .if_req   (ifReq),
    .if_addr  (ifAddr),
    .if_ack   (ifAck),
    .if_rdata (ifRdata),
    .d_req    (dReq),
    .d_we     (dWe),
    .d_addr   (dAddr),
    .d_wdata  (dWdata),
    .d_ack    (dAck),
    .d_rdata  (dRdata),
    .d_err    (dErr),
    .mem_w_en (memWEn),
    .mem_addr (memAddr),
    .mem_wdata(memWdata),
    .mem_rdata(memRdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write on the rising edge.
  assign memRdata = mem[memAddr];
  always @(posedge clk) if (memWEn) mem[memAddr] = memWdata;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Transaction-level model: applies one access in grant order and queues its response.
  task automatic modelOp(input bit isData, input logic [4:0] a, input bit we, input logic [7:0] wd);
    exp_t e;
    e.isData = isData;
    e.err    = 1'b0;
    if (!isData) begin
      e.rdata = refMem[a];
    end else if (we) begin
      if (a < BASE) e.err = 1'b1;
      else          refMem[a] = wd;
      e.rdata = lastDRead;
    end else begin
      lastDRead = refMem[a];
      e.rdata   = lastDRead;
    end
    lastWasData = isData;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit fEn, input logic [4:0] fa, input bit dEn, input bit we,
                               input logic [4:0] da, input logic [7:0] wd,
                               output int fCyc, output int dCyc, output int wenCnt, output int wenCyc);
    bit fPend, dPend;
    int cyc;
    fCyc = -1; dCyc = -1; wenCnt = 0; wenCyc = -1;
    if (fEn && dEn && lastWasData) begin
      modelOp(1'b0, fa, 1'b0, 8'h00);
      modelOp(1'b1, da, we, wd);
    end else if (fEn && dEn) begin
      modelOp(1'b1, da, we, wd);
      modelOp(1'b0, fa, 1'b0, 8'h00);
    end else if (fEn) begin
      modelOp(1'b0, fa, 1'b0, 8'h00);
    end else if (dEn) begin
      modelOp(1'b1, da, we, wd);
    end
    @(negedge clk);
    ifReq = fEn; ifAddr = fa; dReq = dEn; dWe = we; dAddr = da; dWdata = wd;
    fPend = fEn; dPend = dEn; cyc = 1;
    while ((fPend || dPend) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (memWEn) begin wenCnt++; wenCyc = cyc; end
      if (fPend && ifAck) begin fCyc = cyc; fPend = 1'b0; ifReq = 1'b0; end
      if (dPend && dAck)  begin dCyc = cyc; dPend = 1'b0; dReq = 1'b0; end
    end
    checkOutput("roundTimeout", 32'(fPend || dPend), 0);
    ifReq = 1'b0; dReq = 1'b0;
  endtask

  task automatic runRound(input bit fEn, input logic [4:0] fa, input bit dEn, input bit we,
                          input logic [4:0] da, input logic [7:0] wd,
                          output int fCyc, output int dCyc, output int wenCnt, output int wenCyc);
    int expF, expD, expW;
    expF = !fEn ? -1 : ((dEn && !lastWasData) ? 6 : 3);
    expD = !dEn ? -1 : ((fEn && lastWasData) ? 6 : 3);
    expW = (dEn && we && da >= BASE) ? 1 : 0;
    applyStimulus(fEn, fa, dEn, we, da, wd, fCyc, dCyc, wenCnt, wenCyc);
    checkOutput("fetchLatency", fCyc, expF);
    checkOutput("dataLatency", dCyc, expD);
    checkOutput("writeCount", wenCnt, expW);
  endtask

  // Monitor: every ack pops one predicted response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstN && memWEn) checkOutput("writeRegion", 32'(memAddr >= BASE), 1);
      if (rstN && (ifAck || dAck)) begin
        checkOutput("singleAck", 32'(ifAck & dAck), 0);
        checkOutput("queueNonEmpty", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("ackOwner", 32'(dAck), 32'(e.isData));
          if (e.isData) checkOutput("dRdata", dRdata, e.rdata);
          else          checkOutput("ifRdata", ifRdata, e.rdata);
          checkOutput("dErr", 32'(dErr), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int fc, dc, wc, wy, ackSeen, kind;
    logic [8:0] ackMask, idleMask;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[3] = 8'hA5; mem[5] = 8'h55; mem[25] = 8'h77;
    for (int i = 0; i < 32; i++) refMem[i] = mem[i];
    lastWasData = 1'b1; lastDRead = 8'h00;
    ifReq = 0; ifAddr = 0; dReq = 0; dWe = 0; dAddr = 0; dWdata = 0;

    rstN = 1'b1;
    #1 rstN = 1'b0;
    #2;
    checkOutput("resetBusy", 32'(busy), 0);
    checkOutput("resetIfAck", 32'(ifAck), 0);
    checkOutput("resetDAck", 32'(dAck), 0);
    checkOutput("resetWen", 32'(memWEn), 0);
    checkOutput("resetMemAddr", 32'(memAddr), 0);
    checkOutput("resetIfRdata", 32'(ifRdata), 0);
    checkOutput("resetDRdata", 32'(dRdata), 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    runRound(1, 5'd3, 0, 0, 5'd0, 8'h00, fc, dc, wc, wy);
    checkOutput("fetchA5AckCycle", fc, 3);
    checkOutput("fetchA5Data", 32'(ifRdata), 32'hA5);

    runRound(0, 5'd0, 1, 1, 5'd20, 8'h3C, fc, dc, wc, wy);
    checkOutput("writeWenCycle", wy, 2);
    runRound(0, 5'd0, 1, 0, 5'd20, 8'h00, fc, dc, wc, wy);
    checkOutput("readback20", 32'(dRdata), 32'h3C);

    runRound(0, 5'd0, 1, 1, 5'd5, 8'hFF, fc, dc, wc, wy);
    checkOutput("protectWen", wc, 0);
    runRound(1, 5'd5, 0, 0, 5'd0, 8'h00, fc, dc, wc, wy);
    checkOutput("protectKeep", 32'(ifRdata), 32'h55);
    runRound(0, 5'd0, 1, 1, 5'd15, 8'h9A, fc, dc, wc, wy);
    runRound(0, 5'd0, 1, 1, 5'd16, 8'h6B, fc, dc, wc, wy);

    @(negedge clk);
    dReq = 1; dWe = 1; dAddr = 5'd25; dWdata = 8'h11;
    @(posedge clk);
    #1;
    checkOutput("midAccessBusy", 32'(busy), 1);
    checkOutput("midAccessWen", 32'(memWEn), 1);
    checkOutput("midAccessAddr", 32'(memAddr), 25);
    #2 rstN = 1'b0;
    #1;
    checkOutput("abortWen", 32'(memWEn), 0);
    checkOutput("abortBusy", 32'(busy), 0);
    checkOutput("abortMemAddr", 32'(memAddr), 0);
    checkOutput("abortMemWdata", 32'(memWdata), 0);
    dReq = 0;
    lastWasData = 1'b1; lastDRead = 8'h00;
    @(negedge clk);
    checkOutput("abortIfRdata", 32'(ifRdata), 0);
    checkOutput("abortDRdata", 32'(dRdata), 0);
    @(negedge clk);
    rstN = 1'b1;
    ackSeen = 0;
    repeat (5) begin
      @(negedge clk);
      if (dAck || ifAck) ackSeen++;
    end
    checkOutput("noAckAfterReset", ackSeen, 0);

    runRound(1, 5'd7, 1, 0, 5'd25, 8'h00, fc, dc, wc, wy);
    checkOutput("tie1Fetch", fc, 3);
    checkOutput("tie1Data", dc, 6);
    checkOutput("addr25Kept", 32'(dRdata), 32'h77);
    runRound(1, 5'd8, 1, 0, 5'd20, 8'h00, fc, dc, wc, wy);
    checkOutput("tie2Fetch", fc, 3);
    checkOutput("tie2Data", dc, 6);
    runRound(1, 5'd9, 0, 0, 5'd0, 8'h00, fc, dc, wc, wy);
    runRound(1, 5'd10, 1, 0, 5'd16, 8'h00, fc, dc, wc, wy);
    checkOutput("tie3Data", dc, 3);
    checkOutput("tie3Fetch", fc, 6);

    for (int i = 0; i < 3; i++) modelOp(1'b1, 5'd20, 1'b0, 8'h00);
    @(negedge clk);
    dReq = 1; dWe = 0; dAddr = 5'd20;
    ackMask = '0; idleMask = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (dAck)  ackMask[i]  = 1'b1;
      if (!busy) idleMask[i] = 1'b1;
    end
    dReq = 0;
    checkOutput("sustainAcks", 32'(ackMask), 32'b010010010);
    checkOutput("sustainIdle", 32'(idleMask), 32'b100100100);

    for (int r = 0; r < 120; r++) begin
      kind = $urandom_range(0, 2);
      runRound(kind != 1, 5'($urandom_range(0, 31)), kind != 0, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 8'($urandom), fc, dc, wc, wy);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
